// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a shared fixed-point unit, one op in flight.
// Accept-to-response is 3 cycles minimum; requests are held off (accept low) until the unit returns to IDLE.
module fpu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_accept,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_accept,
   output logic [1:0]       fpu_operation,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready,
   output logic             fpu_busy,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_error
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

   state_t           state;
   logic             ptr;
   logic [CW-1:0]    cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;
   logic             sel;
   logic             take;

   // Pointer only breaks ties; a lone requester always wins.
   always_comb begin
      sel         = (req0_valid && req1_valid) ? ptr : req1_valid;
      take        = (state == S_IDLE) && (req0_valid || req1_valid) && !reset;
      req0_accept = take && !sel;
      req1_accept = take && sel;
   end

   assign fpu_operation = op_q;
   assign fpu_operand_1 = a_q;
   assign fpu_operand_2 = b_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ptr        <= 1'b0;
         cnt        <= '0;
         op_q       <= 2'b00;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         fpu_busy   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_error  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take) begin
                  op_q     <= sel ? req1_op : req0_op;
                  a_q      <= sel ? req1_a  : req0_a;
                  b_q      <= sel ? req1_b  : req0_b;
                  id_q     <= sel;
                  fpu_busy <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            // fpu_ready is deliberately not looked at here: it may still be high from the last op.
            S_ISSUE: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (fpu_ready) begin
                  rsp_result <= fpu_result;
                  rsp_error  <= 1'b0;
                  rsp_id     <= id_q;
                  rsp_valid  <= 1'b1;
                  state      <= S_RESPOND;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_result <= '0;
                  rsp_error  <= 1'b1;
                  rsp_id     <= id_q;
                  rsp_valid  <= 1'b1;
                  state      <= S_RESPOND;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESPOND: begin
               rsp_valid <= 1'b0;
               fpu_busy  <= 1'b0;
               ptr       <= ~id_q;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: vector table plus reset/contention sequences, responses checked via a scoreboard queue.
module tb_fpu_arbiter;
   localparam int W  = 32;
   localparam int TO = 8;
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_SQRT = 2'd3;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic [1:0]    req0_op, req1_op;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          req0_accept, req1_accept;
   logic [1:0]    fpu_operation;
   logic [W-1:0]  fpu_operand_1, fpu_operand_2, fpu_result;
   logic          fpu_ready, fpu_busy, rsp_valid, rsp_id, rsp_error;
   logic [W-1:0]  rsp_result;

   fpu_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_accept(req0_accept),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_accept(req1_accept),
      .fpu_operation(fpu_operation), .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
      .fpu_result(fpu_result), .fpu_ready(fpu_ready), .fpu_busy(fpu_busy),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] vmask;
      logic [1:0] op;
      logic [W-1:0] a0, b0, a1, b1;
      int         rdy_at;   // WAIT cycle (1-based) on which ready is returned; 0 = never
      logic       stale;    // hold ready high during ISSUE
      logic       exp_id;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic         err;
   } rsp_t;

   rsp_t sb_q[$];
   int passed = 0;
   int total  = 0;
   logic [1:0]   prev_op  = 2'b00;
   logic [W-1:0] prev_a   = '0;
   logic [W-1:0] prev_res = '0;

   function automatic logic [W-1:0] fpu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return a * b;
         default: return a >> 1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
      else passed++;
   endtask

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
         end else begin
            rsp_t e;
            e = sb_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_error", rsp_error, e.err);
         end
      end
   end

   // Entered and left just after a rising edge with the DUT in IDLE; requests stay valid throughout.
   task automatic run_txn(input vec_t v);
      logic [W-1:0] sa, sbv, res;
      int last;
      sa  = v.exp_id ? v.a1 : v.a0;
      sbv = v.exp_id ? v.b1 : v.b0;
      res = v.exp_err ? '0 : fpu_fn(v.op, sa, sbv);
      req0_valid = v.vmask[0]; req0_op = v.op; req0_a = v.a0; req0_b = v.b0;
      req1_valid = v.vmask[1]; req1_op = v.op; req1_a = v.a1; req1_b = v.b1;
      @(negedge clk);
      chk("idle_rsp_low", rsp_valid, 0);
      chk("idle_busy", fpu_busy, 0);
      chk("hold_op", fpu_operation, prev_op);
      chk("hold_a", fpu_operand_1, prev_a);
      chk("hold_rsp", rsp_result, prev_res);
      chk("accept0", req0_accept, !v.exp_id);
      chk("accept1", req1_accept, v.exp_id);
      sb_q.push_back('{v.exp_id, res, v.exp_err});
      @(posedge clk); #1;
      fpu_ready = v.stale; fpu_result = 32'hDEAD;
      @(negedge clk);
      chk("issue_op", fpu_operation, v.op);
      chk("issue_a", fpu_operand_1, sa);
      chk("issue_b", fpu_operand_2, sbv);
      chk("issue_busy", fpu_busy, 1);
      chk("issue_quiet", {rsp_valid, req0_accept, req1_accept}, 0);
      last = v.exp_err ? TO : v.rdy_at;
      for (int w = 1; w <= last; w++) begin
         @(posedge clk); #1;
         fpu_ready  = (w == v.rdy_at);
         fpu_result = (w == v.rdy_at) ? fpu_fn(v.op, sa, sbv) : 32'hDEAD;
         @(negedge clk);
         chk("wait_quiet", {rsp_valid, req0_accept, req1_accept}, 0);
      end
      @(posedge clk); #1;
      fpu_ready = 1'b0;
      @(negedge clk);
      chk("rsp_latency", rsp_valid, 1);
      chk("respond_quiet", {req0_accept, req1_accept}, 0);
      @(posedge clk); #1;
      prev_op = v.op; prev_a = sa; prev_res = res;
   endtask

   vec_t ctn[4];
   vec_t tbl[10];
   vec_t post;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1);
   end

   initial begin
      ctn[0] = '{2'b11, OP_ADD, 32'h10, 32'h1, 32'h20, 32'h2, 1, 1'b0, 1'b0, 1'b0};
      ctn[1] = '{2'b11, OP_ADD, 32'h11, 32'h1, 32'h21, 32'h2, 1, 1'b0, 1'b1, 1'b0};
      ctn[2] = '{2'b11, OP_SUB, 32'h12, 32'h1, 32'h22, 32'h2, 2, 1'b0, 1'b0, 1'b0};
      ctn[3] = '{2'b11, OP_MUL, 32'h13, 32'h3, 32'h23, 32'h2, 1, 1'b0, 1'b1, 1'b0};
      tbl[0] = '{2'b01, OP_ADD,  32'h600, 32'h900, 32'h0,   32'h0,    1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{2'b11, OP_SUB,  32'h50,  32'h20,  32'h900, 32'h100,  2, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{2'b11, OP_MUL,  32'h3,   32'h7,   32'h5,   32'h9,    1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{2'b01, OP_ADD,  32'h1,   32'h2,   32'h0,   32'h0,    3, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{2'b10, OP_SQRT, 32'h0,   32'h0,   32'h40,  32'h5555, 1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{2'b10, OP_ADD,  32'h0,   32'h0,   32'h77,  32'h11,   1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{2'b01, OP_ADD,  32'hA00, 32'hBC,  32'h0,   32'h0,    5, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{2'b10, OP_MUL,  32'h0,   32'h0,   32'h4,   32'h4,    0, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{2'b01, OP_SUB,  32'h100, 32'h1,   32'h0,   32'h0,    1, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{2'b11, OP_ADD,  32'h31,  32'h2,   32'h40,  32'h8,    TO, 1'b0, 1'b1, 1'b0};
      post   = '{2'b01, OP_MUL,  32'h12,  32'h3,   32'h0,   32'h0,    1, 1'b0, 1'b0, 1'b0};

      reset = 1'b1; fpu_ready = 1'b0; fpu_result = '0;
      req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 32'h5; req0_b = 32'h6;
      req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'h7; req1_b = 32'h8;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_accept", {req0_accept, req1_accept}, 0);
      chk("rst_busy", fpu_busy, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_error}, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_op", fpu_operation, 0);
      chk("rst_operands", {fpu_operand_1, fpu_operand_2}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (ctn[i]) run_txn(ctn[i]);

      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      prev_op = 2'b00; prev_a = '0; prev_res = '0;

      foreach (tbl[i]) run_txn(tbl[i]);

      // Abort mid-WAIT; the aborted request must never be answered or replayed.
      req1_valid = 1'b0; req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h5; req0_b = 32'h6;
      @(negedge clk);
      chk("abort_accept", req0_accept, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("abort_busy", fpu_busy, 1);
      reset = 1'b1;
      #1;
      chk("abort_rst_busy", fpu_busy, 0);
      chk("abort_rst_op", fpu_operation, 0);
      chk("abort_rst_operands", {fpu_operand_1, fpu_operand_2}, 0);
      chk("abort_rst_rsp", {rsp_valid, rsp_id, rsp_error}, 0);
      chk("abort_rst_result", rsp_result, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      prev_op = 2'b00; prev_a = '0; prev_res = '0;
      repeat (6) begin
         @(negedge clk);
         chk("no_replay", {fpu_busy, rsp_valid}, 0);
      end
      @(posedge clk); #1;
      run_txn(post);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("final_hold_op", fpu_operation, prev_op);
      chk("final_hold_rsp", rsp_result, prev_res);
      chk("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
